// File: rtl/rv16_pkg.sv
// Shared types and width defaults for the rv16 instruction fetch unit.
package rv16_pkg;
  localparam int RV16_DATA = 16;
  localparam int RV16_ADDR = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } ifu_state_t;
endpackage

// File: rtl/rv16_instr_fetch_unit_if.sv
// Memory-request and decoder-handshake signals of the fetch unit.
interface rv16_instr_fetch_unit_if
  import rv16_pkg::*;
#(
  parameter int DATA  = RV16_DATA,
  parameter int ADDR  = RV16_ADDR,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             mem_req_out;
  logic [ADDR-1:0]  mem_addr_out;
  logic             mem_gnt_in;
  logic             mem_rvalid_in;
  logic [DATA-1:0]  mem_rdata_in;
  logic             instr_valid_out;
  logic             instr_ready_in;
  logic [DATA-1:0]  rv16_dminstr_out;
  logic [ADDR-1:0]  instr_pc_out;
  logic [CNT_W-1:0] fifo_count_out;

  modport master (
    output mem_req_out, mem_addr_out, instr_valid_out, rv16_dminstr_out,
           instr_pc_out, fifo_count_out,
    input  mem_gnt_in, mem_rvalid_in, mem_rdata_in, instr_ready_in
  );

  modport slave (
    input  mem_req_out, mem_addr_out, instr_valid_out, rv16_dminstr_out,
           instr_pc_out, fifo_count_out,
    output mem_gnt_in, mem_rvalid_in, mem_rdata_in, instr_ready_in
  );
endinterface

// File: rtl/rv16_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs for the decode stage.
module rv16_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != '0);
endmodule

// File: rtl/rv16_instr_fetch_unit.sv
// Fetch unit: PC, credit-limited memory requests, redirect flush, and the instruction FIFO.
module rv16_instr_fetch_unit
  import rv16_pkg::*;
#(
  parameter int          DATA     = RV16_DATA,
  parameter int          ADDR     = RV16_ADDR,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            rv16_ifu_clock,
  input  logic            rv16_ifu_reset,
  input  logic            rv16_ifu_enable_in,
  input  logic            redirect_valid_in,
  input  logic [ADDR-1:0] redirect_pc_in,
  rv16_instr_fetch_unit_if.master bus
);
  localparam int              CNT_W  = $clog2(DEPTH + 1);
  localparam logic [ADDR-1:0] RST_PC = ADDR'(RESET_PC);

  ifu_state_t            state;
  logic [ADDR-1:0]       fetch_pc;
  logic [ADDR-1:0]       resp_pc;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      discard;
  logic [CNT_W-1:0]      pending;
  logic [CNT_W-1:0]      pending_next;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_valid;
  logic [ADDR+DATA-1:0]  fifo_rdata;
  logic                  credit_ok;
  logic                  grant;
  logic                  keep;
  logic                  push;
  logic                  pop;

  // Outstanding requests plus buffered entries never exceed the FIFO depth.
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(DEPTH);

  assign bus.mem_req_out  = (state == ST_FETCH) && rv16_ifu_enable_in &&
                            !redirect_valid_in && credit_ok;
  assign bus.mem_addr_out = fetch_pc;

  assign grant = bus.mem_req_out && bus.mem_gnt_in;
  assign keep  = bus.mem_rvalid_in && (discard == '0);
  assign push  = keep && !redirect_valid_in;
  assign pop   = fifo_valid && bus.instr_ready_in;

  // Only one of discard/inflight is non-zero, so their sum is the total still owed.
  assign pending      = discard + inflight;
  assign pending_next = pending - CNT_W'(bus.mem_rvalid_in && (pending != '0));

  always_ff @(posedge rv16_ifu_clock or negedge rv16_ifu_reset) begin
    if (!rv16_ifu_reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RST_PC;
      resp_pc  <= RST_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid_in) begin
      fetch_pc <= redirect_pc_in;
      resp_pc  <= redirect_pc_in;
      inflight <= '0;
      discard  <= pending_next;
      if (state != ST_IDLE) state <= (pending_next != '0) ? ST_FLUSH : ST_FETCH;
    end else begin
      if (grant) fetch_pc <= fetch_pc + ADDR'(1);
      if (keep)  resp_pc  <= resp_pc + ADDR'(1);
      inflight <= inflight + CNT_W'(grant) - CNT_W'(keep);
      if (bus.mem_rvalid_in && (discard != '0)) discard <= discard - CNT_W'(1);
      case (state)
        ST_IDLE:  if (rv16_ifu_enable_in) state <= ST_FETCH;
        ST_FETCH: state <= ST_FETCH;
        ST_FLUSH: if ((discard == '0) || (bus.mem_rvalid_in && (discard == CNT_W'(1))))
                    state <= ST_FETCH;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  rv16_fetch_fifo #(
    .WIDTH (ADDR + DATA),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (rv16_ifu_clock),
    .rst_n (rv16_ifu_reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid_in),
    .wdata ({resp_pc, bus.mem_rdata_in}),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign bus.instr_valid_out  = fifo_valid;
  assign bus.rv16_dminstr_out = fifo_valid ? fifo_rdata[DATA-1:0] : '0;
  assign bus.instr_pc_out     = fifo_valid ? fifo_rdata[ADDR+DATA-1:DATA] : RST_PC;
  assign bus.fifo_count_out   = fifo_count;
endmodule
